// File: rtl/pla_cfg_loader_if.sv
// Configuration word stream (valid/ready) feeding the PLA programming-plane loader.
interface pla_cfg_loader_if #(
  parameter int WORD_WIDTH = 32
);
  logic [WORD_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/pla_cfg_loader.sv
// PLA programming-plane loader: streams words into shadow AND/OR rows, then commits them atomically.
// Optional trailing XOR checksum word is enabled by defining PLA_LOADER_CHK_EN.
module pla_cfg_loader #(
  parameter int IN_WIDTH   = 16,
  parameter int OUT_WIDTH  = 8,
  parameter int AND_WIDTH  = 32,
  parameter int WORD_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  pla_cfg_loader_if.slave        in_if,
  output logic [2*IN_WIDTH-1:0]  and_sel [AND_WIDTH],
  output logic [AND_WIDTH-1:0]   or_sel  [OUT_WIDTH],
  output logic                   busy,
  output logic                   cfg_valid,
  output logic                   err
);

  localparam int AND_RW = 2 * IN_WIDTH;
  localparam int AW     = (AND_RW + WORD_WIDTH - 1) / WORD_WIDTH;
  localparam int OW     = (AND_WIDTH + WORD_WIDTH - 1) / WORD_WIDTH;
  localparam int MAXR   = (AND_WIDTH > OUT_WIDTH) ? AND_WIDTH : OUT_WIDTH;
  localparam int MAXW   = (AW > OW) ? AW : OW;
  localparam int ROW_W  = (MAXR > 1) ? $clog2(MAXR) : 1;
  localparam int WRD_W  = (MAXW > 1) ? $clog2(MAXW) : 1;
  localparam int AIW    = (AND_WIDTH > 1) ? $clog2(AND_WIDTH) : 1;
  localparam int OIW    = (OUT_WIDTH > 1) ? $clog2(OUT_WIDTH) : 1;

  localparam logic [ROW_W-1:0] AROW_LAST = ROW_W'(AND_WIDTH - 1);
  localparam logic [ROW_W-1:0] OROW_LAST = ROW_W'(OUT_WIDTH - 1);
  localparam logic [WRD_W-1:0] AW_LAST   = WRD_W'(AW - 1);
  localparam logic [WRD_W-1:0] OW_LAST   = WRD_W'(OW - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_AND,
    S_LOAD_OR,
`ifdef PLA_LOADER_CHK_EN
    S_CHECK,
`endif
    S_COMMIT,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [ROW_W-1:0] row_q;
  logic [WRD_W-1:0] wrd_q;

  // Shadow rows are kept word-aligned; excess high bits are dropped at commit.
  logic [AW*WORD_WIDTH-1:0] and_sh_q [AND_WIDTH];
  logic [OW*WORD_WIDTH-1:0] or_sh_q  [OUT_WIDTH];
  logic [AND_RW-1:0]        and_live_q [AND_WIDTH];
  logic [AND_WIDTH-1:0]     or_live_q  [OUT_WIDTH];
  logic                     cfg_valid_q;

  logic go, xfer, ld_and, ld_or, in_load, commit_ok, row_done_a, row_done_o;
  logic [AIW-1:0] aidx;
  logic [OIW-1:0] oidx;

  assign aidx       = row_q[AIW-1:0];
  assign oidx       = row_q[OIW-1:0];
  assign xfer       = in_if.in_valid & in_if.in_ready;
  assign row_done_a = xfer && ld_and && (wrd_q == AW_LAST);
  assign row_done_o = xfer && ld_or  && (wrd_q == OW_LAST);

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (start) state_d = S_LOAD_AND;
      S_LOAD_AND:     if (row_done_a && row_q == AROW_LAST) state_d = S_LOAD_OR;
`ifdef PLA_LOADER_CHK_EN
      S_LOAD_OR:      if (row_done_o && row_q == OROW_LAST) state_d = S_CHECK;
      S_CHECK:        if (xfer) state_d = S_COMMIT;
`else
      S_LOAD_OR:      if (row_done_o && row_q == OROW_LAST) state_d = S_COMMIT;
`endif
      S_COMMIT:       state_d = S_DONE;
      default:        state_d = S_IDLE;
    endcase
  end

  // outputs
  always_comb begin
    ld_and          = (state_q == S_LOAD_AND);
    ld_or           = (state_q == S_LOAD_OR);
    in_load         = ld_and | ld_or;
    go              = start && (state_q == S_IDLE || state_q == S_DONE);
    busy            = !(state_q == S_IDLE || state_q == S_DONE);
`ifdef PLA_LOADER_CHK_EN
    in_if.in_ready  = in_load || (state_q == S_CHECK);
`else
    in_if.in_ready  = in_load;
`endif
  end

  // row/word counters and shadow writes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q <= '0;
      wrd_q <= '0;
      for (int r = 0; r < AND_WIDTH; r++) and_sh_q[r] <= '0;
      for (int r = 0; r < OUT_WIDTH; r++) or_sh_q[r]  <= '0;
    end else if (go) begin
      row_q <= '0;
      wrd_q <= '0;
    end else if (xfer && in_load) begin
      if (ld_and) begin
        for (int w = 0; w < AW; w++)
          if (wrd_q == WRD_W'(w)) and_sh_q[aidx][w*WORD_WIDTH +: WORD_WIDTH] <= in_if.in_data;
      end else begin
        for (int w = 0; w < OW; w++)
          if (wrd_q == WRD_W'(w)) or_sh_q[oidx][w*WORD_WIDTH +: WORD_WIDTH] <= in_if.in_data;
      end
      if (row_done_a || row_done_o) begin
        wrd_q <= '0;
        // Row counter wraps when a plane is finished.
        if ((ld_and && row_q == AROW_LAST) || (ld_or && row_q == OROW_LAST)) row_q <= '0;
        else row_q <= row_q + ROW_W'(1);
      end else begin
        wrd_q <= wrd_q + WRD_W'(1);
      end
    end
  end

  // live arrays only move on a successful commit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_valid_q <= 1'b0;
      for (int r = 0; r < AND_WIDTH; r++) and_live_q[r] <= '0;
      for (int r = 0; r < OUT_WIDTH; r++) or_live_q[r]  <= '0;
    end else if (state_q == S_COMMIT && commit_ok) begin
      cfg_valid_q <= 1'b1;
      for (int r = 0; r < AND_WIDTH; r++) and_live_q[r] <= and_sh_q[r][AND_RW-1:0];
      for (int r = 0; r < OUT_WIDTH; r++) or_live_q[r]  <= or_sh_q[r][AND_WIDTH-1:0];
    end
  end

`ifdef PLA_LOADER_CHK_EN
  logic [WORD_WIDTH-1:0] acc_q;
  logic                  chk_ok_q, err_q;

  // The checksum verdict is registered and acted on in COMMIT, so pass and fail both settle one edge later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      chk_ok_q <= 1'b0;
      err_q    <= 1'b0;
    end else if (go) begin
      acc_q    <= '0;
      chk_ok_q <= 1'b0;
      err_q    <= 1'b0;
    end else if (xfer && in_load) begin
      acc_q <= acc_q ^ in_if.in_data;
    end else if (xfer && state_q == S_CHECK) begin
      chk_ok_q <= (in_if.in_data == acc_q);
    end else if (state_q == S_COMMIT && !chk_ok_q) begin
      err_q <= 1'b1;
    end
  end

  assign commit_ok = chk_ok_q;
  assign err       = err_q;
`else
  assign commit_ok = 1'b1;
  assign err       = 1'b0;
`endif

  assign cfg_valid = cfg_valid_q;
  assign and_sel   = and_live_q;
  assign or_sel    = or_live_q;

endmodule

// File: tb/tb_pla_cfg_loader.sv
// Directed + randomized bench for pla_cfg_loader with a row-level reference model of the live arrays.
module tb_pla_cfg_loader;
  localparam int IW  = 16;
  localparam int OWD = 8;
  localparam int AWD = 32;
  localparam int WW  = 32;
  localparam int AW  = (2*IW + WW - 1) / WW;
  localparam int OW  = (AWD + WW - 1) / WW;
  localparam int NW  = AWD*AW + OWD*OW;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [2*IW-1:0] and_sel [AWD];
  logic [AWD-1:0]  or_sel  [OWD];
  logic busy, cfg_valid, err;

  pla_cfg_loader_if #(.WORD_WIDTH(WW)) bus ();

  pla_cfg_loader #(.IN_WIDTH(IW), .OUT_WIDTH(OWD), .AND_WIDTH(AWD), .WORD_WIDTH(WW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_if(bus),
    .and_sel(and_sel), .or_sel(or_sel), .busy(busy), .cfg_valid(cfg_valid), .err(err)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  logic [2*IW-1:0] exp_and [AWD];
  logic [AWD-1:0]  exp_or  [OWD];
  logic            exp_cfg = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: rows are filled in stream order, low word first, AND plane then OR plane.
  task automatic model_commit(input logic [WW-1:0] w[$]);
    int k = 0;
    for (int r = 0; r < AWD; r++) begin
      logic [AW*WW-1:0] row;
      row = '0;
      for (int j = 0; j < AW; j++) row[j*WW +: WW] = w[k++];
      exp_and[r] = row[2*IW-1:0];
    end
    for (int r = 0; r < OWD; r++) begin
      logic [OW*WW-1:0] row;
      row = '0;
      for (int j = 0; j < OW; j++) row[j*WW +: WW] = w[k++];
      exp_or[r] = row[AWD-1:0];
    end
    exp_cfg = 1'b1;
  endtask

  task automatic model_clear();
    for (int r = 0; r < AWD; r++) exp_and[r] = '0;
    for (int r = 0; r < OWD; r++) exp_or[r]  = '0;
    exp_cfg = 1'b0;
  endtask

  task automatic check_live(input string tag);
    for (int r = 0; r < AWD; r++) chk($sformatf("%s and_sel[%0d]", tag, r), and_sel[r], exp_and[r]);
    for (int r = 0; r < OWD; r++) chk($sformatf("%s or_sel[%0d]", tag, r), or_sel[r], exp_or[r]);
    chk({tag, " cfg_valid"}, cfg_valid, exp_cfg);
  endtask

  // Sends stream words [first, last); first==0 issues start. Completing the stream checks commit timing.
  task automatic run_load(input logic [WW-1:0] w[$], input int first, input int last,
                          input bit gap, input bit bad, input int pulse_at);
    logic [WW-1:0] x;
    logic [WW-1:0] s[$];
    int total;
    x = '0;
    s = w;
    foreach (w[i]) x ^= w[i];
`ifdef PLA_LOADER_CHK_EN
    s.push_back(bad ? (x ^ 32'h1) : x);
`endif
    total = s.size();
    if (first == 0) begin
      start = 1'b1; step(); start = 1'b0;
      chk("after start busy", busy, 1'b1);
      chk("after start in_ready", bus.in_ready, 1'b1);
      chk("after start err", err, 1'b0);
    end
    for (int i = first; i < last && i < total; i++) begin
      if (gap && (i % 2 == 1)) begin
        bus.in_valid = 1'b0; bus.in_data = $urandom; step();
        chk("gap busy", busy, 1'b1);
      end
      chk($sformatf("in_ready before word %0d", i), bus.in_ready, 1'b1);
      if (i == pulse_at) start = 1'b1;
      bus.in_valid = 1'b1; bus.in_data = s[i]; step();
      start = 1'b0;
    end
    bus.in_valid = 1'b0;
    if (last >= total) begin
      chk("commit cycle busy", busy, 1'b1);
      chk("commit cycle cfg_valid", cfg_valid, exp_cfg);
      step();
      if (!bad) model_commit(w);
      chk("done busy", busy, 1'b0);
      chk("done cfg_valid", cfg_valid, exp_cfg);
      chk("done err", err, bad);
    end
  endtask

  logic [WW-1:0] qa[$], qr[$], qf[$], qb[$], qz[$];

  initial begin
    model_clear();
    bus.in_valid = 1'b1;
    bus.in_data  = $urandom;
    #12;
    chk("reset in_ready", bus.in_ready, 1'b0);
    chk("reset busy", busy, 1'b0);
    chk("reset err", err, 1'b0);
    check_live("reset");
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      bus.in_data = $urandom; step();
      chk("idle in_ready", bus.in_ready, 1'b0);
      chk("idle busy", busy, 1'b0);
    end
    bus.in_valid = 1'b0;
    check_live("idle");

    for (int i = 0; i < NW; i++) qa.push_back(32'hA500_0000 + i);
    run_load(qa, 0, 1 << 20, 1'b0, 1'b0, -1);
    chk("and_sel[31] pattern", and_sel[31], 32'hA500_001F);
    chk("or_sel[7] pattern", or_sel[7], 32'hA500_0027);
    check_live("pattern");

    run_load(qa, 0, 1 << 20, 1'b1, 1'b0, -1);
    check_live("stalled");

    for (int i = 0; i < NW; i++) qr.push_back($urandom);
    run_load(qr, 0, 1 << 20, 1'b0, 1'b0, 15);
    check_live("random with ignored start");

    for (int i = 0; i < NW; i++) qf.push_back(32'hFFFF_FFFF);
    run_load(qf, 0, 20, 1'b0, 1'b0, -1);
    chk("mid reload busy", busy, 1'b1);
    check_live("mid reload");
    run_load(qf, 20, 1 << 20, 1'b0, 1'b0, -1);
    check_live("all ones");

`ifdef PLA_LOADER_CHK_EN
    for (int i = 0; i < NW; i++) qb.push_back($urandom);
    run_load(qb, 0, 1 << 20, 1'b0, 1'b1, -1);
    check_live("bad checksum");
    run_load(qa, 0, 0, 1'b0, 1'b0, -1);
    run_load(qa, 0, 1 << 20, 1'b0, 1'b0, -1);
    check_live("after bad checksum");
`endif

    for (int i = 0; i < NW; i++) qz.push_back($urandom);
    run_load(qz, 0, 25, 1'b0, 1'b0, -1);
    #2 rst_n = 1'b0;
    #1;
    model_clear();
    chk("async reset busy", busy, 1'b0);
    chk("async reset in_ready", bus.in_ready, 1'b0);
    chk("async reset err", err, 1'b0);
    check_live("async reset");
    #2 rst_n = 1'b1;
    run_load(qz, 0, NW - 1, 1'b0, 1'b0, -1);
    chk("reload short busy", busy, 1'b1);
    chk("reload short cfg_valid", cfg_valid, 1'b0);
    run_load(qz, NW - 1, 1 << 20, 1'b0, 1'b0, -1);
    check_live("full reload");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
